// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter: two result FIFOs drained round-robin onto one registered broadcast port
module cdb_fifo #(
   parameter int RoB_WIDTH  = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  flush_in,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [RoB_WIDTH-1:0]  push_index,
   input  logic [31:0]           push_data,
   input  logic                  pop,
   output logic                  not_empty,
   output logic [RoB_WIDTH-1:0]  head_index,
   output logic [31:0]           head_data
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [RoB_WIDTH+31:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic [CW-1:0]         count;
   logic                  push_ok;

   // Ready never looks at this cycle's pop: a full FIFO stays closed even while draining.
   assign push_ready = (count < CW'(FIFO_DEPTH)) && !flush_in;
   assign push_ok    = push_valid && push_ready;
   assign not_empty  = (count != '0);
   assign {head_index, head_data} = mem[head];

   always_ff @(posedge clk_in) begin
      if (push_ok)
         mem[tail] <= {push_index, push_data};
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || flush_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_ok)
            tail <= tail + PW'(1);
         if (pop)
            head <= head + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
      end
   end
endmodule

module cdb_arbiter #(
   parameter int RoB_WIDTH  = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  flush_in,
   input  logic                  lsb_valid,
   output logic                  lsb_ready,
   input  logic [RoB_WIDTH-1:0]  lsb_index,
   input  logic [31:0]           lsb_data,
   input  logic                  rs_valid,
   output logic                  rs_ready,
   input  logic [RoB_WIDTH-1:0]  rs_index,
   input  logic [31:0]           rs_data,
   output logic                  cdb_valid,
   output logic [RoB_WIDTH-1:0]  cdb_index,
   output logic [31:0]           cdb_data,
   output logic                  cdb_src
);
   logic                 lsb_ne;
   logic                 rs_ne;
   logic [RoB_WIDTH-1:0] lsb_head_index;
   logic [RoB_WIDTH-1:0] rs_head_index;
   logic [31:0]          lsb_head_data;
   logic [31:0]          rs_head_data;
   logic                 grant_lsb;
   logic                 grant_rs;
   logic                 last_grant;

   cdb_fifo #(.RoB_WIDTH(RoB_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_lsb_fifo (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .flush_in   (flush_in),
      .push_valid (lsb_valid),
      .push_ready (lsb_ready),
      .push_index (lsb_index),
      .push_data  (lsb_data),
      .pop        (grant_lsb && !flush_in),
      .not_empty  (lsb_ne),
      .head_index (lsb_head_index),
      .head_data  (lsb_head_data)
   );

   cdb_fifo #(.RoB_WIDTH(RoB_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rs_fifo (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .flush_in   (flush_in),
      .push_valid (rs_valid),
      .push_ready (rs_ready),
      .push_index (rs_index),
      .push_data  (rs_data),
      .pop        (grant_rs && !flush_in),
      .not_empty  (rs_ne),
      .head_index (rs_head_index),
      .head_data  (rs_head_data)
   );

   // last_grant: 1 = LSB won most recently, so a tie goes to the other source.
   assign grant_lsb = lsb_ne && (!rs_ne || !last_grant);
   assign grant_rs  = rs_ne && (!lsb_ne || last_grant);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cdb_valid  <= 1'b0;
         cdb_index  <= '0;
         cdb_data   <= '0;
         cdb_src    <= 1'b0;
         last_grant <= 1'b1;
      end else if (flush_in) begin
         cdb_valid <= 1'b0;
      end else if (grant_lsb) begin
         cdb_valid  <= 1'b1;
         cdb_index  <= lsb_head_index;
         cdb_data   <= lsb_head_data;
         cdb_src    <= 1'b1;
         last_grant <= 1'b1;
      end else if (grant_rs) begin
         cdb_valid  <= 1'b1;
         cdb_index  <= rs_head_index;
         cdb_data   <= rs_head_data;
         cdb_src    <= 1'b0;
         last_grant <= 1'b0;
      end else begin
         cdb_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector table plus randomized queue-model check of cdb_arbiter
module tb_cdb_arbiter;
   localparam int D = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        lsb_valid = 1'b0;
   logic        lsb_ready;
   logic [2:0]  lsb_index = '0;
   logic [31:0] lsb_data = '0;
   logic        rs_valid = 1'b0;
   logic        rs_ready;
   logic [2:0]  rs_index = '0;
   logic [31:0] rs_data = '0;
   logic        cdb_valid;
   logic [2:0]  cdb_index;
   logic [31:0] cdb_data;
   logic        cdb_src;

   cdb_arbiter #(.RoB_WIDTH(3), .FIFO_DEPTH(D)) dut (
      .clk_in(clk), .rst_in(rst), .flush_in(flush),
      .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_index(lsb_index), .lsb_data(lsb_data),
      .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_index(rs_index), .rs_data(rs_data),
      .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_data(cdb_data), .cdb_src(cdb_src)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, fl, lv; logic [2:0] li; logic [31:0] ld;
      logic rv; logic [2:0] ri; logic [31:0] rd;
      logic chk_rdy, e_lr, e_rr, e_v; logic [2:0] e_i; logic [31:0] e_d; logic e_s;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: one queue per source, plus the round-robin memory.
   logic [34:0] lq[$];
   logic [34:0] rq[$];
   logic        m_lg = 1'b1;
   logic        m_v = 1'b0;
   logic [2:0]  m_i = '0;
   logic [31:0] m_d = '0;
   logic        m_s = 1'b0;

   task automatic add(input logic r, f, lv, input logic [2:0] li, input logic [31:0] ld,
                      input logic rv, input logic [2:0] ri, input logic [31:0] rd,
                      input logic cr, elr, err, ev, input logic [2:0] ei,
                      input logic [31:0] ed, input logic es);
      vec_t v;
      v.rst = r; v.fl = f; v.lv = lv; v.li = li; v.ld = ld; v.rv = rv; v.ri = ri; v.rd = rd;
      v.chk_rdy = cr; v.e_lr = elr; v.e_rr = err; v.e_v = ev; v.e_i = ei; v.e_d = ed; v.e_s = es;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at vector %0d: actual=%h required=%h", name, n_vec, act, exp);
      end
   endtask

   function automatic bit m_lready();
      return lq.size() < D && !flush;
   endfunction

   function automatic bit m_rready();
      return rq.size() < D && !flush;
   endfunction

   // Advances the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      bit lr, rr, take_lsb;
      logic [34:0] e;
      lr = m_lready();
      rr = m_rready();
      if (rst) begin
         lq.delete(); rq.delete();
         m_lg = 1'b1; m_v = 1'b0; m_i = '0; m_d = '0; m_s = 1'b0;
      end else if (flush) begin
         lq.delete(); rq.delete();
         m_v = 1'b0;
      end else begin
         if (lq.size() == 0 && rq.size() == 0) begin
            m_v = 1'b0;
         end else begin
            if (lq.size() == 0) take_lsb = 1'b0;
            else if (rq.size() == 0) take_lsb = 1'b1;
            else take_lsb = !m_lg;
            e = take_lsb ? lq.pop_front() : rq.pop_front();
            m_v = 1'b1; m_i = e[34:32]; m_d = e[31:0]; m_s = take_lsb; m_lg = take_lsb;
         end
         if (lsb_valid && lr) lq.push_back({lsb_index, lsb_data});
         if (rs_valid && rr) rq.push_back({rs_index, rs_data});
      end
   endtask

   initial begin
      //  rst fl lv li ld           rv ri rd            crdy lr rr  v  i  d             s
      add(1, 0, 0, 0, 0,           0, 0, 0,            0, 0, 0,    0, 0, 0,            0);
      add(1, 0, 0, 0, 0,           0, 0, 0,            0, 0, 0,    0, 0, 0,            0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    0, 0, 0,            0);
      add(0, 0, 0, 0, 0,           1, 3, 32'h12345678, 1, 1, 1,    0, 0, 0,            0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    1, 3, 32'h12345678, 0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    0, 3, 32'h12345678, 0);
      add(1, 0, 0, 0, 0,           0, 0, 0,            0, 0, 0,    0, 0, 0,            0);
      add(0, 0, 1, 1, 32'hA,       1, 2, 32'hB,        1, 1, 1,    0, 0, 0,            0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    1, 2, 32'hB,        0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    1, 1, 32'hA,        1);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    0, 1, 32'hA,        1);
      add(0, 0, 1, 4, 32'h40,      1, 6, 32'h60,       1, 1, 1,    0, 1, 32'hA,        1);
      add(0, 0, 1, 5, 32'h50,      0, 0, 0,            1, 1, 1,    1, 6, 32'h60,       0);
      add(0, 0, 1, 7, 32'h70,      0, 0, 0,            1, 0, 1,    1, 4, 32'h40,       1);
      add(0, 0, 1, 7, 32'h70,      0, 0, 0,            1, 1, 1,    1, 5, 32'h50,       1);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    1, 7, 32'h70,       1);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    0, 7, 32'h70,       1);
      add(0, 0, 1, 2, 32'h22,      1, 1, 32'h11,       1, 1, 1,    0, 7, 32'h70,       1);
      add(0, 0, 0, 0, 0,           1, 3, 32'h33,       1, 1, 1,    1, 1, 32'h11,       0);
      add(0, 1, 0, 0, 0,           1, 4, 32'h44,       1, 0, 0,    0, 1, 32'h11,       0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    0, 1, 32'h11,       0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    0, 1, 32'h11,       0);
      add(0, 0, 1, 6, 32'h66,      1, 7, 32'h77,       1, 1, 1,    0, 1, 32'h11,       0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    1, 6, 32'h66,       1);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    1, 7, 32'h77,       0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    0, 7, 32'h77,       0);
      add(0, 0, 1, 1, 32'h01,      1, 2, 32'h02,       1, 1, 1,    0, 7, 32'h77,       0);
      add(1, 0, 0, 0, 0,           0, 0, 0,            0, 0, 0,    0, 0, 0,            0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    0, 0, 0,            0);
      add(0, 0, 0, 0, 0,           0, 0, 0,            1, 1, 1,    0, 0, 0,            0);

      @(posedge clk); #1;
      foreach (tbl[k]) begin
         rst = tbl[k].rst; flush = tbl[k].fl;
         lsb_valid = tbl[k].lv; lsb_index = tbl[k].li; lsb_data = tbl[k].ld;
         rs_valid = tbl[k].rv; rs_index = tbl[k].ri; rs_data = tbl[k].rd;
         #1;
         if (tbl[k].chk_rdy) begin
            chk("lsb_ready", 32'(lsb_ready), 32'(tbl[k].e_lr));
            chk("rs_ready", 32'(rs_ready), 32'(tbl[k].e_rr));
         end
         @(posedge clk);
         model_edge();
         #1;
         chk("cdb_valid", 32'(cdb_valid), 32'(tbl[k].e_v));
         chk("cdb_index", 32'(cdb_index), 32'(tbl[k].e_i));
         chk("cdb_data", cdb_data, tbl[k].e_d);
         chk("cdb_src", 32'(cdb_src), 32'(tbl[k].e_s));
         n_vec++;
      end

      // Sustained contention first, then random traffic with occasional flush/reset.
      for (int c = 0; c < 600; c++) begin
         if (c < 40) begin
            rst = 1'b0; flush = 1'b0; lsb_valid = 1'b1; rs_valid = 1'b1;
         end else begin
            rst = ($urandom_range(99) == 0);
            flush = ($urandom_range(29) == 0);
            lsb_valid = ($urandom_range(9) < 6);
            rs_valid = ($urandom_range(9) < 6);
         end
         lsb_index = 3'($urandom); lsb_data = $urandom;
         rs_index = 3'($urandom); rs_data = $urandom;
         #1;
         if (!rst) begin
            chk("rand_lsb_ready", 32'(lsb_ready), 32'(m_lready()));
            chk("rand_rs_ready", 32'(rs_ready), 32'(m_rready()));
         end
         @(posedge clk);
         model_edge();
         #1;
         chk("rand_cdb_valid", 32'(cdb_valid), 32'(m_v));
         chk("rand_cdb_index", 32'(cdb_index), 32'(m_i));
         chk("rand_cdb_data", cdb_data, m_d);
         chk("rand_cdb_src", 32'(cdb_src), 32'(m_s));
         n_vec++;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
